// File: rtl/cfr_output_monitor.sv
// Windowed residual-peak monitor for the CFR output: per-window peak |x|^2, its index and over-threshold count.
// Optional per-window power sum is built when CFR_OUTPUT_MONITOR_POWER_SUM_EN is defined.
module cfr_output_monitor #(
   parameter int DATA_WIDTH = 16,
   parameter int WIN_WIDTH  = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [DATA_WIDTH-1:0]             data_i_in,
   input  logic [DATA_WIDTH-1:0]             data_q_in,
   input  logic                              ctrl_enable,
   input  logic [WIN_WIDTH-1:0]              ctrl_window_len,
   input  logic [2*DATA_WIDTH-1:0]           ctrl_threshold_sq,
   output logic                              stat_valid,
   output logic [2*DATA_WIDTH-1:0]           stat_peak_sq,
   output logic [WIN_WIDTH-1:0]              stat_peak_idx,
   output logic [WIN_WIDTH:0]                stat_over_cnt,
   output logic [2*DATA_WIDTH+WIN_WIDTH-1:0] stat_power_sum
);

   localparam int MAG_W = 2 * DATA_WIDTH;
   localparam int SUM_W = MAG_W + WIN_WIDTH;
   localparam int CNT_W = WIN_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

   logic signed [DATA_WIDTH-1:0] i_s1, q_s1;
   logic                         en_s1;
   logic signed [MAG_W-1:0]      i_ext, q_ext, sq_i, sq_q;
   logic [MAG_W-1:0]             mag_c;
   logic [MAG_W-1:0]             mag_s2;
   logic                         en_s2;

   state_t                       state_q, state_d;
   logic                         win_first, win_acc, stat_load;
   logic [WIN_WIDTH-1:0]         cur_idx;
   logic [WIN_WIDTH-1:0]         len_q, idx_q;
   logic [MAG_W-1:0]             peak_q;
   logic [WIN_WIDTH-1:0]         peak_idx_q;
   logic [CNT_W-1:0]             over_q;
   logic                         over_hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         i_s1  <= '0;
         q_s1  <= '0;
         en_s1 <= 1'b0;
      end else begin
         i_s1  <= data_i_in;
         q_s1  <= data_q_in;
         en_s1 <= ctrl_enable;
      end
   end

   // Both squares are non-negative and their sum is at most 2^(2W-1), so MAG_W bits never wrap.
   always_comb begin
      i_ext = MAG_W'(i_s1);
      q_ext = MAG_W'(q_s1);
      sq_i  = i_ext * i_ext;
      sq_q  = q_ext * q_ext;
      mag_c = $unsigned(sq_i) + $unsigned(sq_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mag_s2 <= '0;
         en_s2  <= 1'b0;
      end else begin
         mag_s2 <= mag_c;
         en_s2  <= en_s1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // IDLE looks one stage ahead (en_s1) so START lines up with the first qualified sample at S2.
   // DONE also opens the next window on its own sample, keeping back-to-back windows gapless.
   always_comb begin
      state_d   = state_q;
      win_first = 1'b0;
      win_acc   = 1'b0;
      stat_load = 1'b0;
      cur_idx   = '0;
      unique case (state_q)
         IDLE: begin
            if (en_s1) state_d = START;
         end
         START, DONE: begin
            stat_load = (state_q == DONE);
            if (en_s2) begin
               win_first = 1'b1;
               state_d   = (ctrl_window_len == '0) ? DONE : RUN;
            end else begin
               state_d = en_s1 ? START : IDLE;
            end
         end
         RUN: begin
            if (en_s2) begin
               win_acc = 1'b1;
               cur_idx = idx_q + WIN_WIDTH'(1);
               state_d = (cur_idx == len_q) ? DONE : RUN;
            end else begin
               state_d = en_s1 ? START : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign over_hit = (mag_s2 > ctrl_threshold_sq);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_q      <= '0;
         idx_q      <= '0;
         peak_q     <= '0;
         peak_idx_q <= '0;
         over_q     <= '0;
      end else if (win_first) begin
         len_q      <= ctrl_window_len;
         idx_q      <= '0;
         peak_q     <= mag_s2;
         peak_idx_q <= '0;
         over_q     <= CNT_W'(over_hit);
      end else if (win_acc) begin
         idx_q <= cur_idx;
         if (mag_s2 > peak_q) begin
            peak_q     <= mag_s2;
            peak_idx_q <= cur_idx;
         end
         if (over_hit) over_q <= over_q + CNT_W'(1);
      end else if (state_q == IDLE) begin
         idx_q      <= '0;
         peak_q     <= '0;
         peak_idx_q <= '0;
         over_q     <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_valid    <= 1'b0;
         stat_peak_sq  <= '0;
         stat_peak_idx <= '0;
         stat_over_cnt <= '0;
      end else begin
         stat_valid <= stat_load;
         if (stat_load) begin
            stat_peak_sq  <= peak_q;
            stat_peak_idx <= peak_idx_q;
            stat_over_cnt <= over_q;
         end
      end
   end

`ifdef CFR_OUTPUT_MONITOR_POWER_SUM_EN
   logic [SUM_W-1:0] sum_q, stat_sum_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum_q      <= '0;
         stat_sum_q <= '0;
      end else begin
         if (win_first)              sum_q <= SUM_W'(mag_s2);
         else if (win_acc)           sum_q <= sum_q + SUM_W'(mag_s2);
         else if (state_q == IDLE)   sum_q <= '0;
         if (stat_load) stat_sum_q <= sum_q;
      end
   end

   assign stat_power_sum = stat_sum_q;
`else
   assign stat_power_sum = '0;
`endif

endmodule

// File: tb/tb_cfr_output_monitor.sv
// Scoreboard bench for cfr_output_monitor: a window-level reference model predicts each stat report.
module tb_cfr_output_monitor;

   localparam int DW = 16;
   localparam int WW = 16;
   localparam int NC = 4096;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic [DW-1:0]        data_i_in = '0;
   logic [DW-1:0]        data_q_in = '0;
   logic                 ctrl_enable = 1'b0;
   logic [WW-1:0]        ctrl_window_len = '0;
   logic [2*DW-1:0]      ctrl_threshold_sq = '0;
   logic                 stat_valid;
   logic [2*DW-1:0]      stat_peak_sq;
   logic [WW-1:0]        stat_peak_idx;
   logic [WW:0]          stat_over_cnt;
   logic [2*DW+WW-1:0]   stat_power_sum;

   cfr_output_monitor #(.DATA_WIDTH(DW), .WIN_WIDTH(WW)) dut (
      .clk(clk), .rst(rst),
      .data_i_in(data_i_in), .data_q_in(data_q_in),
      .ctrl_enable(ctrl_enable), .ctrl_window_len(ctrl_window_len),
      .ctrl_threshold_sq(ctrl_threshold_sq),
      .stat_valid(stat_valid), .stat_peak_sq(stat_peak_sq),
      .stat_peak_idx(stat_peak_idx), .stat_over_cnt(stat_over_cnt),
      .stat_power_sum(stat_power_sum)
   );

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @edge %0d: got 0x%0h, expected 0x%0h", name, edge_cnt, act, exp);
      end
   endtask

   // Per-input-cycle record; index c means "value present before posedge c".
   int                rec_i   [NC];
   int                rec_q   [NC];
   bit                rec_en  [NC];
   bit                rec_rst [NC];
   int                rec_len [NC];
   longint unsigned   rec_thr [NC];

   typedef struct {
      int              cyc;
      longint unsigned peak;
      int              idx;
      int              over;
      longint unsigned sum;
   } exp_t;
   exp_t sb[$];

   bit              in_win = 0;
   int              win_len = 0;
   int              win_over = 0;
   longint unsigned win_mags[$];

   // Sample s is accumulated at edge s+2 (live threshold / latched length from then) and reported at s+3.
   task automatic model_sample(input int s);
      bit              qual;
      longint unsigned m, pk, sm;
      int              pi;
      exp_t            e;
      qual = rec_en[s] && rec_rst[s] && rec_rst[s+1] && rec_rst[s+2] && rec_rst[s+3];
      if (!qual) begin
         in_win = 0;
         win_mags.delete();
         return;
      end
      if (!in_win) begin
         in_win   = 1;
         win_len  = rec_len[s+2];
         win_over = 0;
         win_mags.delete();
      end
      m = longint'(rec_i[s]) * rec_i[s] + longint'(rec_q[s]) * rec_q[s];
      win_mags.push_back(m);
      if (m > rec_thr[s+2]) win_over++;
      if (win_mags.size() == win_len + 1) begin
         pk = win_mags[0]; pi = 0; sm = 0;
         foreach (win_mags[k]) begin
            sm += win_mags[k];
            if (win_mags[k] > pk) begin pk = win_mags[k]; pi = k; end
         end
         e.cyc  = s + 3;
         e.peak = pk;
         e.idx  = pi;
         e.over = win_over;
`ifdef CFR_OUTPUT_MONITOR_POWER_SUM_EN
         e.sum  = sm;
`else
         e.sum  = 0;
`endif
         sb.push_back(e);
         in_win = 0;
         win_mags.delete();
      end
   endtask

   task automatic step(input int i, input int q, input bit en, input int len,
                       input longint unsigned thr, input bit r);
      int c;
      @(negedge clk);
      c = edge_cnt + 1;
      if (c >= NC) begin
         $display("FAIL cycle_budget: got %0d cycles, limit %0d", c, NC);
         $fatal(1, "cycle budget exhausted");
      end
      rst               = r;
      data_i_in         = DW'(i);
      data_q_in         = DW'(q);
      ctrl_enable       = en;
      ctrl_window_len   = WW'(len);
      ctrl_threshold_sq = (2*DW)'(thr);
      rec_i[c] = i; rec_q[c] = q; rec_en[c] = en; rec_rst[c] = r;
      rec_len[c] = len; rec_thr[c] = thr;
      if (c >= 3) model_sample(c - 3);
   endtask

   function automatic int rnd_data();
      int r;
      r = int'($urandom_range(0, 7));
      if (r == 0) return -32768;
      if (r == 1) return 32767;
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   // Monitor: pops the scoreboard whenever a report appears, otherwise checks the outputs hold.
   longint unsigned last_peak = 0, last_sum = 0;
   int              last_idx = 0, last_over = 0;

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            check("rst_valid", stat_valid, 0);
            check("rst_stats", {stat_peak_sq, stat_peak_idx, stat_over_cnt} == '0 && stat_power_sum == '0, 1);
            last_peak = 0; last_idx = 0; last_over = 0; last_sum = 0;
         end else begin
            while (sb.size() > 0 && sb[0].cyc < edge_cnt) begin
               e = sb.pop_front();
               check("missed_valid_edge", edge_cnt, e.cyc);
            end
            if (stat_valid) begin
               if (sb.size() == 0 || sb[0].cyc != edge_cnt) begin
                  check("unexpected_valid", 1, 0);
               end else begin
                  e = sb.pop_front();
                  check("peak_sq",   stat_peak_sq,   e.peak);
                  check("peak_idx",  stat_peak_idx,  e.idx);
                  check("over_cnt",  stat_over_cnt,  e.over);
                  check("power_sum", stat_power_sum, e.sum);
                  last_peak = e.peak; last_idx = e.idx; last_over = e.over; last_sum = e.sum;
               end
            end else begin
               check("hold_stats",
                     (stat_peak_sq == last_peak) && (stat_peak_idx == last_idx) &&
                     (stat_over_cnt == last_over) && (stat_power_sum == last_sum), 1);
            end
         end
      end
   end

   initial begin
      int len, i, q, pk;
      longint unsigned thr;

      // Reset held with enable high and random data.
      for (int k = 0; k < 6; k++) step(rnd_data(), rnd_data(), 1, 7, 0, 0);
      for (int k = 0; k < 3; k++) step(0, 0, 0, 7, 0, 1);

      // Single strong peak at index 3.
      for (int k = 0; k < 8; k++) step((k == 3) ? 32767 : 0, 0, 1, 7, 64'h1000_0000, 1);
      for (int k = 0; k < 5; k++) step(0, 0, 0, 7, 0, 1);

      // Full-scale negative on both rails.
      for (int k = 0; k < 4; k++) step(-32768, -32768, 1, 3, 0, 1);
      for (int k = 0; k < 5; k++) step(0, 0, 0, 3, 0, 1);

      // One-sample windows back to back.
      for (int k = 0; k < 12; k++) step(rnd_data(), rnd_data(), 1, 0, {32'h0, $urandom}, 1);
      for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0, 1);

      // Enable drop mid-window, then a fresh full window.
      for (int k = 0; k < 5; k++) step(rnd_data(), rnd_data(), 1, 15, 0, 1);
      for (int k = 0; k < 4; k++) step(0, 0, 0, 15, 0, 1);
      pk = int'($urandom_range(1, 15));
      for (int k = 0; k < 16; k++)
         step((k == pk) ? 32767 : int'($urandom_range(0, 200)), 0, 1, 15, 64'h100, 1);
      for (int k = 0; k < 5; k++) step(0, 0, 0, 15, 0, 1);

      // Tied peaks, window length changed mid-window.
      for (int k = 0; k < 10; k++)
         step((k == 2 || k == 6) ? 64 : int'($urandom_range(0, 40)), (k == 2 || k == 6) ? 0 : int'($urandom_range(0, 40)),
              1, (k >= 5) ? 3 : 9, 64'h800, 1);
      for (int k = 0; k < 8; k++) step(int'($urandom_range(0, 40)), 0, 1, 3, 64'h800, 1);
      for (int k = 0; k < 5; k++) step(0, 0, 0, 3, 0, 1);

      // Reset in the middle of a window.
      for (int k = 0; k < 6; k++) step(rnd_data(), rnd_data(), 1, 10, 64'h2000_0000, 1);
      for (int k = 0; k < 2; k++) step(rnd_data(), rnd_data(), 1, 10, 64'h2000_0000, 0);
      for (int k = 0; k < 12; k++) step(rnd_data(), rnd_data(), 1, 10, 64'h2000_0000, 1);
      for (int k = 0; k < 5; k++) step(0, 0, 0, 10, 0, 1);

      // Randomised traffic with enable gaps and live control changes.
      len = 5;
      thr = 64'h4000_0000;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 39) == 0) len = int'($urandom_range(0, 12));
         if ($urandom_range(0, 29) == 0) begin
            case ($urandom_range(0, 2))
               0:       thr = 0;
               1:       thr = 64'h4000_0000;
               default: thr = {32'h0, $urandom};
            endcase
         end
         i = rnd_data();
         q = rnd_data();
         step(i, q, ($urandom_range(0, 19) != 0), len, thr, 1);
      end

      for (int k = 0; k < 10; k++) step(0, 0, 0, len, 0, 1);
      @(posedge clk);
      #2;
      check("scoreboard_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
